// File: rtl/ofm_acc_wb.sv
// ============================================================================
// Module   : ofm_acc_wb
// Purpose  : Output-feature-map accumulator and write-back stage. Partial
//            sums from the PE array are accumulated per pixel over
//            ic_num+1 input-channel passes. The finished tile is then
//            streamed out over a valid/ready interface.
// Revision : 1.0 - initial release
// Config   : OFM_ACC_WB_RELU_EN - when defined, negative results are
//            clamped to zero on output (ReLU).
// Ports    :
//   clk         in   clock, rising edge
//   rstn        in   asynchronous active-low reset
//   start_i     in   begin convolution, latch ic_num_i / pix_num_i
//   ic_num_i    in   input-channel passes per tile minus 1
//   pix_num_i   in   pixels per pass minus 1
//   pvalid_i    in   psum_i valid
//   psum_i      in   signed partial sum
//   stop_i      in   return to IDLE once the current tile has drained
//   out_ready_i in   sink accepts out_data_o
//   out_valid_o out  out_data_o valid
//   out_data_o  out  accumulated pixel
//   out_last_o  out  final pixel of the tile
//   busy_o      out  draining; upstream must hold pvalid_i low
//   ovf_err_o   out  sticky: a pvalid_i arrived outside ACC and was dropped
// ============================================================================
`default_nettype none

module ofm_acc_wb #(
  parameter int TILE_LEN     = 16,
  parameter int PSUM_WIDTH   = 20,
  parameter int ACC_WIDTH    = 28,
  parameter int CH_CNT_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start_i,
  input  logic [CH_CNT_WIDTH-1:0]      ic_num_i,
  input  logic [$clog2(TILE_LEN)-1:0]  pix_num_i,
  input  logic                         pvalid_i,
  input  logic signed [PSUM_WIDTH-1:0] psum_i,
  input  logic                         stop_i,
  input  logic                         out_ready_i,
  output logic                         out_valid_o,
  output logic [ACC_WIDTH-1:0]         out_data_o,
  output logic                         out_last_o,
  output logic                         busy_o,
  output logic                         ovf_err_o
);

  localparam int PIX_W = $clog2(TILE_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state_q;
  logic [CH_CNT_WIDTH-1:0] ic_num_q;
  logic [PIX_W-1:0]        pix_num_q;
  logic [PIX_W-1:0]        pix_cnt_q;
  logic [CH_CNT_WIDTH-1:0] ic_cnt_q;
  logic [PIX_W-1:0]        rd_cnt_q;
  logic                    stop_pend_q;
  logic                    ovf_err_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic [ACC_WIDTH-1:0]    out_data_q;

  // Accumulator storage is deliberately not reset: pass 0 overwrites it.
  logic [ACC_WIDTH-1:0]    acc_q [TILE_LEN];

  logic [ACC_WIDTH-1:0]    psum_ext;
  logic [ACC_WIDTH-1:0]    acc_d;
  logic                    acc_we;
  logic                    pix_end;
  logic                    tile_end;
  logic                    stop_now;
  logic [PIX_W-1:0]        rd_nxt;

  function automatic logic [ACC_WIDTH-1:0] out_fmt(input logic [ACC_WIDTH-1:0] v);
`ifdef OFM_ACC_WB_RELU_EN
    return v[ACC_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    psum_ext = ACC_WIDTH'(psum_i);  // signed source -> sign extension
    acc_d    = (ic_cnt_q == '0) ? psum_ext : (acc_q[pix_cnt_q] + psum_ext);
    pix_end  = (pix_cnt_q == pix_num_q);
    tile_end = pix_end && (ic_cnt_q == ic_num_q);
    // A stop at a tile boundary (nothing accumulated yet) leaves at once.
    stop_now = stop_i && (pix_cnt_q == '0) && (ic_cnt_q == '0);
    acc_we   = (state_q == S_ACC) && pvalid_i && !stop_now;
    rd_nxt   = rd_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (acc_we) begin
      acc_q[pix_cnt_q] <= acc_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      ic_num_q    <= '0;
      pix_num_q   <= '0;
      pix_cnt_q   <= '0;
      ic_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      stop_pend_q <= 1'b0;
      ovf_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            ic_num_q    <= ic_num_i;
            pix_num_q   <= pix_num_i;
            pix_cnt_q   <= '0;
            ic_cnt_q    <= '0;
            ovf_err_q   <= 1'b0;
            stop_pend_q <= 1'b0;
            state_q     <= S_ACC;
          end else if (pvalid_i) begin
            ovf_err_q <= 1'b1;
          end
        end

        S_ACC: begin
          if (stop_now) begin
            state_q <= S_IDLE;
          end else begin
            if (stop_i) begin
              stop_pend_q <= 1'b1;
            end
            if (pvalid_i) begin
              if (pix_end) begin
                pix_cnt_q <= '0;
                if (tile_end) begin
                  ic_cnt_q    <= '0;
                  rd_cnt_q    <= '0;
                  state_q     <= S_DRAIN;
                  out_valid_q <= 1'b1;
                  out_last_q  <= (pix_num_q == '0);
                  // With a single pixel, pixel 0 is the one written this cycle.
                  out_data_q  <= out_fmt((pix_num_q == '0) ? acc_d : acc_q[0]);
                end else begin
                  ic_cnt_q <= ic_cnt_q + 1'b1;
                end
              end else begin
                pix_cnt_q <= pix_cnt_q + 1'b1;
              end
            end
          end
        end

        S_DRAIN: begin
          if (pvalid_i) begin
            ovf_err_q <= 1'b1;
          end
          if (stop_i) begin
            stop_pend_q <= 1'b1;
          end
          if (out_valid_q && out_ready_i) begin
            if (out_last_q) begin
              rd_cnt_q    <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              stop_pend_q <= 1'b0;
              state_q     <= (stop_pend_q || stop_i) ? S_IDLE : S_ACC;
            end else begin
              rd_cnt_q   <= rd_nxt;
              out_data_q <= out_fmt(acc_q[rd_nxt]);
              out_last_q <= (rd_nxt == pix_num_q);
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = (state_q == S_DRAIN);
  assign ovf_err_o   = ovf_err_q;

endmodule

`default_nettype wire
